snake_dir_ctrl: RTL

//   Upstream stage of the snake graphics/game block. Converts four raw push-buttons into the
//   4-bit moveState direction code that the graphics block consumes.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/snake_dir_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game: direction codes consumed by the
// graphics block, the pause run-state enum and direction helper functions.
package snake_pkg;

    // moveState codes; the graphics block imports these same values
    localparam logic [3:0] DIR_UP    = 4'd0;
    localparam logic [3:0] DIR_DOWN  = 4'd1;
    localparam logic [3:0] DIR_LEFT  = 4'd2;
    localparam logic [3:0] DIR_RIGHT = 4'd3;
    localparam logic [3:0] DIR_PAUSE = 4'd4;

    // Number of direction buttons; button index equals its direction code
    localparam int NUM_DIRS = 4;

    // Run state of the controller when pause support is built in
    typedef enum logic {
        RUN_ACTIVE = 1'b0,
        RUN_PAUSED = 1'b1
    } runState_t;

    // Opposite direction: up/down and left/right pairs differ only in bit 0
    function automatic logic [3:0] oppositeDir(input logic [3:0] dir);
        return dir ^ 4'd1;
    endfunction

    // A request is acceptable when it neither repeats nor reverses the current heading
    function automatic logic isTurn(input logic [3:0] current, input logic [3:0] request);
        return (request != current) && (request != oppositeDir(current));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button to a clean level and a single-cycle press pulse.
// Raw input goes through a 2-FF synchroniser, then must hold a new level for
// DEBOUNCE_CYCLES consecutive clocks before the stable level follows it.
// The press pulse marks the 0->1 transition of the stable level only.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q;
    logic             stablePrev_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             stable_d;

    // Two flops bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Count how long the synchronised level has disagreed with the stable level
    always_comb begin
        count_d  = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (count_q == CNT_LAST) begin
                stable_d = sync_q;
                count_d  = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Register the debounce counter, the stable level and its delayed copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            stable_q     <= 1'b0;
            stablePrev_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            stable_q     <= stable_d;
            stablePrev_q <= stable_q;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~stablePrev_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: debounces the four direction buttons, picks one
// press per cycle (up > down > left > right), rejects 180-degree reversals and
// registers the resulting moveState plus a one-cycle dir_change pulse.
// Build option SNAKE_PAUSE_EN adds a debounced pause button that toggles a
// paused state driving moveState = 4 and restores the previous heading.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int INIT_DIR        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    output logic [3:0] moveState,
    output logic       dir_change
);

    localparam logic [3:0] INIT_CODE = 4'(INIT_DIR);

    logic [NUM_DIRS-1:0] btnRaw;
    logic [NUM_DIRS-1:0] dirPress;
    logic [NUM_DIRS-1:0] unusedDirLevel;
    logic                reqValid;
    logic [3:0]          reqDir;

    logic [3:0]          moveState_q;
    logic [3:0]          moveState_d;
    logic                dirChange_q;
    logic                dirChange_d;

    // Index of each button equals its direction code, so arbitration can use the index directly
    assign btnRaw = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dirDebounce
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btnRaw[i]),
            .level(unusedDirLevel[i]),
            .press(dirPress[i])
        );
    end

`ifdef SNAKE_PAUSE_EN
    logic       pausePress;
    logic       unusedPauseLevel;
    runState_t  runState_q;
    runState_t  runState_d;
    logic [3:0] resumeDir_q;
    logic [3:0] resumeDir_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pauseDebounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (btn_pause),
        .level(unusedPauseLevel),
        .press(pausePress)
    );
`else
    logic unusedPauseBtn;
    assign unusedPauseBtn = btn_pause;
`endif

    // Fixed-priority pick: the lowest code among simultaneous presses wins, the rest are dropped
    always_comb begin
        reqValid = 1'b0;
        reqDir   = DIR_UP;
        for (int i = NUM_DIRS - 1; i >= 0; i--) begin
            if (dirPress[i]) begin
                reqValid = 1'b1;
                reqDir   = 4'(i);
            end
        end
    end

    // Decide the next heading: pause toggling first, then turns that are neither repeats nor reversals
    always_comb begin
        moveState_d = moveState_q;
        dirChange_d = 1'b0;
`ifdef SNAKE_PAUSE_EN
        runState_d  = runState_q;
        resumeDir_d = resumeDir_q;
        if (pausePress) begin
            dirChange_d = 1'b1;
            if (runState_q == RUN_PAUSED) begin
                runState_d  = RUN_ACTIVE;
                moveState_d = resumeDir_q;
            end else begin
                runState_d  = RUN_PAUSED;
                resumeDir_d = moveState_q;
                moveState_d = DIR_PAUSE;
            end
        end else if (runState_q == RUN_ACTIVE && reqValid && isTurn(moveState_q, reqDir)) begin
            moveState_d = reqDir;
            dirChange_d = 1'b1;
        end
`else
        if (reqValid && isTurn(moveState_q, reqDir)) begin
            moveState_d = reqDir;
            dirChange_d = 1'b1;
        end
`endif
    end

    // Output and pause-state registers; reset restores the configured starting heading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moveState_q <= INIT_CODE;
            dirChange_q <= 1'b0;
`ifdef SNAKE_PAUSE_EN
            runState_q  <= RUN_ACTIVE;
            resumeDir_q <= INIT_CODE;
`endif
        end else begin
            moveState_q <= moveState_d;
            dirChange_q <= dirChange_d;
`ifdef SNAKE_PAUSE_EN
            runState_q  <= runState_d;
            resumeDir_q <= resumeDir_d;
`endif
        end
    end

    assign moveState  = moveState_q;
    assign dir_change = dirChange_q;

endmodule
